// File: rtl/sm_regdump_uart.sv
// sm_regdump_uart
// ---------------
// Register dump engine for the CPU debug port. On a start request it walks
// debug addresses 0..NREGS-1. For each address it captures the value and
// sends it over a transmit-only 8N1 UART as 8 lowercase hex digits, then CR LF.
//
// Parameters
//   BAUD_DIV  clock cycles per UART bit (>= 2)
//   NREGS     number of debug addresses dumped, starting at 0 (1..32)
//
// Ports
//   clk      in   system clock (same clock as the CPU top)
//   rst_n    in   asynchronous active-low reset
//   start    in   dump request, sampled only while idle
//   regAddr  out  debug port address to the CPU top
//   regData  in   debug port data; combinational in regAddr
//   uart_tx  out  serial output, LSB first, idle high
//   busy     out  high from start acceptance until dump completion
//   done     out  one-cycle pulse at dump completion
module sm_regdump_uart #(
  parameter int BAUD_DIV = 434,
  parameter int NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int             BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [4:0]     LAST_REG  = 5'(NREGS - 1);

  typedef enum logic [2:0] {IDLE, SETADDR, LATCH, TX, FINISH} state_t;

  state_t         stateReg, stateNext;
  logic [BW-1:0]  baudReg, baudNext;
  logic [3:0]     bitReg, bitNext;      // 0 = start, 1..8 = data, 9 = stop
  logic [3:0]     charReg, charNext;    // 0..7 hex digits, 8 = CR, 9 = LF
  logic [4:0]     idxReg, idxNext;
  logic [31:0]    shadowReg, shadowNext;
  logic           txReg, txNext;
  logic [7:0]     charByte;

  // ASCII code of character charIdx of the line for value.
  function automatic logic [7:0] encodeChar(input logic [3:0] charIdx,
                                            input logic [31:0] value);
    logic [3:0] nib;
    case (charIdx[2:0])
      3'd0:    nib = value[31:28];
      3'd1:    nib = value[27:24];
      3'd2:    nib = value[23:20];
      3'd3:    nib = value[19:16];
      3'd4:    nib = value[15:12];
      3'd5:    nib = value[11:8];
      3'd6:    nib = value[7:4];
      default: nib = value[3:0];
    endcase
    if (charIdx == 4'd8)      return 8'h0D;
    else if (charIdx == 4'd9) return 8'h0A;
    else if (nib < 4'd10)     return 8'h30 + {4'h0, nib};
    else                      return 8'h57 + {4'h0, nib};  // 0xa -> 0x61
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      baudReg   <= '0;
      bitReg    <= '0;
      charReg   <= '0;
      idxReg    <= '0;
      shadowReg <= '0;
      txReg     <= 1'b1;
    end else begin
      stateReg  <= stateNext;
      baudReg   <= baudNext;
      bitReg    <= bitNext;
      charReg   <= charNext;
      idxReg    <= idxNext;
      shadowReg <= shadowNext;
      txReg     <= txNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    baudNext   = baudReg;
    bitNext    = bitReg;
    charNext   = charReg;
    idxNext    = idxReg;
    shadowNext = shadowReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          idxNext   = '0;
          stateNext = SETADDR;
        end
      end
      SETADDR: stateNext = LATCH;  // one cycle for regData to settle
      LATCH: begin
        shadowNext = regData;
        charNext   = '0;
        bitNext    = '0;
        baudNext   = '0;
        stateNext  = TX;
      end
      TX: begin
        if (baudReg == BAUD_LAST) begin
          baudNext = '0;
          if (bitReg == 4'd9) begin
            bitNext = '0;
            if (charReg == 4'd9) begin
              charNext = '0;
              if (idxReg == LAST_REG) begin
                stateNext = FINISH;
              end else begin
                idxNext   = idxReg + 5'd1;
                stateNext = SETADDR;
              end
            end else begin
              charNext = charReg + 4'd1;
            end
          end else begin
            bitNext = bitReg + 4'd1;
          end
        end else begin
          baudNext = baudReg + 1'b1;
        end
      end
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // The serial line is registered from the next-state view, so it changes
  // exactly on the edge that starts a bit and never glitches.
  always_comb begin
    charByte = encodeChar(charNext, shadowNext);
    txNext   = 1'b1;
    if (stateNext == TX) begin
      if (bitNext == 4'd0)       txNext = 1'b0;
      else if (bitNext <= 4'd8)  txNext = charByte[3'(bitNext - 4'd1)];
    end
  end

  assign busy    = (stateReg == SETADDR) || (stateReg == LATCH) || (stateReg == TX);
  assign done    = (stateReg == FINISH);
  assign regAddr = busy ? idxReg : 5'd0;
  assign uart_tx = txReg;

endmodule
